// File: rtl/ndn_name_packer_pkg.sv
// Shared types for the NDN name ingress path: word/name shapes, FIFO entry and
// packer state encoding.
package ndn_pkg;

  localparam int unsigned WORD_SIZE       = 32;
  localparam int unsigned MAX_NAME_LENGTH = 8;
  localparam int unsigned LEN_W           = $clog2(MAX_NAME_LENGTH + 1);
  localparam int unsigned IDX_W           = (MAX_NAME_LENGTH > 1) ? $clog2(MAX_NAME_LENGTH) : 1;

  typedef logic [WORD_SIZE-1:0] word_t;
  typedef word_t                name_t [MAX_NAME_LENGTH];
  typedef logic [LEN_W-1:0]     len_t;

  typedef struct {
    name_t name;
    len_t  len;
    logic  err;
  } name_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DISCARD
  } packer_state_t;

  function automatic name_entry_t empty_entry();
    name_entry_t e;
    for (int unsigned i = 0; i < MAX_NAME_LENGTH; i++) e.name[i] = '0;
    e.len = '0;
    e.err = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/ndn_name_packer_if.sv
// Word-stream ingress and assembled-name egress handshakes of the name packer.
interface ndn_name_packer_if;
  import ndn_pkg::*;

  logic  word_valid_in;
  logic  word_ready_out;
  word_t word_in;
  logic  word_last_in;

  name_t name_out;
  len_t  name_len_out;
  logic  name_err_out;
  logic  name_valid_out;
  logic  name_ready_in;

  modport slave (
    input  word_valid_in, word_in, word_last_in, name_ready_in,
    output word_ready_out, name_out, name_len_out, name_err_out, name_valid_out
  );

  modport master (
    output word_valid_in, word_in, word_last_in, name_ready_in,
    input  word_ready_out, name_out, name_len_out, name_err_out, name_valid_out
  );

endinterface

// File: rtl/ndn_name_fifo.sv
// First-word fall-through FIFO of assembled names; head is read straight from
// the storage flops so it holds steady while the consumer stalls.
module ndn_name_fifo
  import ndn_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  name_entry_t entry_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output name_entry_t head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  name_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [OCC_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == OCC_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A pop frees a slot in the same cycle, so push-on-full is legal alongside it.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= empty_entry();
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= entry_i;
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      if (do_pop) rptr_q <= rptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + OCC_W'(1);
        2'b01:   count_q <= count_q - OCC_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ndn_name_packer.sv
// Serial name-component packer: assembles words into fixed-width names, truncates
// and counts over-long names, and queues results for the FIB lookup pipeline.
module ndn_name_packer
  import ndn_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ndn_name_packer_if.slave     bus,
  output logic [CNT_W-1:0]     discard_cnt_out
);

  packer_state_t    state_q, state_d;
  name_t            buf_q, buf_d;
  len_t             idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             accept, push, fifo_full, fifo_empty, pop;
  name_entry_t      push_entry, head;

  // Ready looks only at registered full; a same-cycle pop does not help.
  assign bus.word_ready_out = rst_n & ((state_q == DISCARD) | ~fifo_full);
  assign accept             = bus.word_valid_in & bus.word_ready_out;
  assign pop                = bus.name_ready_in & ~fifo_empty;
  assign cnt_inc            = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    push_entry = empty_entry();
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          for (int unsigned i = 0; i < MAX_NAME_LENGTH; i++) buf_d[i] = '0;
          buf_d[0] = bus.word_in;
          if (bus.word_last_in) begin
            push           = 1'b1;
            push_entry.len = len_t'(1);
          end else begin
            idx_d   = len_t'(1);
            state_d = COLLECT;
          end
        end
        COLLECT: begin
          if (idx_q < len_t'(MAX_NAME_LENGTH)) begin
            buf_d[idx_q[IDX_W-1:0]] = bus.word_in;
            if (bus.word_last_in) begin
              push           = 1'b1;
              push_entry.len = idx_q + len_t'(1);
              state_d        = IDLE;
            end else begin
              idx_d = idx_q + len_t'(1);
            end
          end else begin
            // First excess word: commit the truncated name now, drop the rest.
            push           = 1'b1;
            push_entry.len = len_t'(MAX_NAME_LENGTH);
            push_entry.err = 1'b1;
            cnt_d          = cnt_inc;
            state_d        = bus.word_last_in ? IDLE : DISCARD;
          end
        end
        DISCARD: begin
          cnt_d = cnt_inc;
          if (bus.word_last_in) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    push_entry.name = buf_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < MAX_NAME_LENGTH; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  ndn_name_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  assign bus.name_out       = head.name;
  assign bus.name_len_out   = head.len;
  assign bus.name_err_out   = head.err;
  assign bus.name_valid_out = ~fifo_empty;
  assign discard_cnt_out    = cnt_q;

endmodule

// File: tb/tb_ndn_name_packer.sv
// Bench for ndn_name_packer: directed and random names checked against a
// name-level reference queue; a CNT_W=4 twin shares the stimulus for saturation.
module tb_ndn_name_packer;
  import ndn_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ndn_name_packer_if bus ();
  ndn_name_packer_if bus4 ();
  logic [15:0] disc;
  logic [3:0]  disc4;

  ndn_name_packer #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .discard_cnt_out(disc));
  ndn_name_packer #(.FIFO_DEPTH(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .discard_cnt_out(disc4));

  assign bus4.word_valid_in = bus.word_valid_in;
  assign bus4.word_in       = bus.word_in;
  assign bus4.word_last_in  = bus.word_last_in;
  assign bus4.name_ready_in = bus.name_ready_in;

  typedef struct {
    logic [31:0] w [8];
    int unsigned len;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        last_e, mon_e, zero_e;
  int unsigned n_vec = 0, n_err = 0, model_disc = 0;
  bit          rand_ready = 1'b0;

  function automatic bit name_match(input exp_t e);
    for (int i = 0; i < 8; i++) if (bus.name_out[i] !== e.w[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_name(input string tag, input exp_t e);
    n_vec++;
    assert (name_match(e)) else begin
      n_err++;
      $error("FAIL %s: observed w0=%h w1=%h w7=%h, expected w0=%h w1=%h w7=%h", tag,
             bus.name_out[0], bus.name_out[1], bus.name_out[7], e.w[0], e.w[1], e.w[7]);
    end
  endtask

  // Every popped head must equal the oldest outstanding expected name.
  always @(negedge clk) begin
    #1;
    if (rst_n && bus.name_valid_out && bus.name_ready_in) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL pop_unexpected: observed name len=%0d, expected none", bus.name_len_out);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        assert (name_match(mon_e) && bus.name_len_out === LEN_W'(mon_e.len) &&
                bus.name_err_out === mon_e.err) else begin
          n_err++;
          $error("FAIL pop_entry: observed w0=%h len=%0d err=%b, expected w0=%h len=%0d err=%b",
                 bus.name_out[0], bus.name_len_out, bus.name_err_out,
                 mon_e.w[0], mon_e.len, mon_e.err);
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] w, input logic last);
    int unsigned t = 0;
    @(negedge clk);
    bus.word_valid_in = 1'b1;
    bus.word_in       = w;
    bus.word_last_in  = last;
    if (rand_ready) bus.name_ready_in = 1'($urandom_range(0, 1));
    while (!bus.word_ready_out && t < 100) begin
      @(negedge clk);
      if (rand_ready) bus.name_ready_in = 1'($urandom_range(0, 1));
      t++;
    end
    chk("accept_in_bound", bus.word_ready_out, 1);
    @(posedge clk);
  endtask

  task automatic send_idle();
    @(negedge clk);
    bus.word_valid_in = 1'b0;
    bus.word_last_in  = 1'b0;
  endtask

  // Expectation is queued before the words go out: a commit can never precede it.
  task automatic send_name(input int unsigned n);
    logic [31:0] words [64];
    exp_t e;
    for (int i = 0; i < 64; i++) words[i] = $urandom;
    for (int unsigned i = 0; i < 8; i++) e.w[i] = (i < n) ? words[i] : 32'h0;
    e.len = (n > 8) ? 8 : n;
    e.err = (n > 8);
    if (n > 8) model_disc += n - 8;
    last_e = e;
    exp_q.push_back(e);
    for (int unsigned i = 0; i < n; i++) send_word(words[i], i == n - 1);
  endtask

  task automatic drain(input string tag);
    int unsigned t = 0;
    @(negedge clk);
    bus.name_ready_in = 1'b1;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic chk_disc(input string tag);
    chk({tag, "_cnt16"}, disc, model_disc);
    chk({tag, "_cnt4"}, disc4, (model_disc > 15) ? 15 : model_disc);
  endtask

  initial begin
    exp_t e5;
    for (int i = 0; i < 8; i++) zero_e.w[i] = 32'h0;
    zero_e.len = 0;
    zero_e.err = 1'b0;
    bus.word_valid_in = 1'b0;
    bus.word_in       = '0;
    bus.word_last_in  = 1'b0;
    bus.name_ready_in = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", bus.word_ready_out, 0);
    chk("rst_valid", bus.name_valid_out, 0);
    chk("rst_len", bus.name_len_out, 0);
    chk("rst_err", bus.name_err_out, 0);
    chk_name("rst_name", zero_e);
    chk_disc("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_ready", bus.word_ready_out, 1);

    // 3-word name, one-cycle visibility
    send_name(3);
    #1;
    chk("A_valid", bus.name_valid_out, 1);
    chk_name("A_name", last_e);
    chk("A_len", bus.name_len_out, 3);
    chk("A_err", bus.name_err_out, 0);
    send_idle();
    @(posedge clk);
    #1;
    chk("A_valid_drop", bus.name_valid_out, 0);

    // Over-long name then a single-word name
    send_name(10);
    #1;
    chk_disc("W");
    send_name(1);
    #1;
    chk("B_len", bus.name_len_out, 1);
    chk("B_err", bus.name_err_out, 0);
    send_idle();
    drain("W_drain");

    // Fill the FIFO with the consumer stalled, then release with a held word
    @(negedge clk);
    bus.name_ready_in = 1'b0;
    repeat (4) send_name(1);
    for (int i = 0; i < 8; i++) e5.w[i] = 32'h0;
    e5.w[0] = $urandom;
    e5.len  = 1;
    e5.err  = 1'b0;
    exp_q.push_back(e5);
    @(negedge clk);
    bus.word_valid_in = 1'b1;
    bus.word_in       = e5.w[0];
    bus.word_last_in  = 1'b1;
    #1;
    chk("F_ready_full", bus.word_ready_out, 0);
    chk("F_valid_full", bus.name_valid_out, 1);
    @(negedge clk);
    bus.name_ready_in = 1'b1;
    #1;
    chk("F_ready_pop_cycle", bus.word_ready_out, 0);
    @(posedge clk);
    #1;
    chk("F_ready_after_pop", bus.word_ready_out, 1);
    @(posedge clk);
    send_idle();
    drain("F_drain");

    // Random names with a randomly stalling consumer
    rand_ready = 1'b1;
    repeat (12) send_name($urandom_range(1, 12));
    rand_ready = 1'b0;
    send_idle();
    drain("R_drain");
    chk_disc("R");

    // Reset in the middle of a name
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.word_valid_in = 1'b0;
    bus.word_last_in  = 1'b0;
    exp_q.delete();
    model_disc = 0;
    #1;
    chk("M_ready", bus.word_ready_out, 0);
    chk("M_valid", bus.name_valid_out, 0);
    chk("M_len", bus.name_len_out, 0);
    chk("M_err", bus.name_err_out, 0);
    chk_name("M_name", zero_e);
    chk_disc("M");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("M_rel_ready", bus.word_ready_out, 1);
    send_name(5);
    #1;
    chk_name("M_next_name", last_e);
    chk("M_next_len", bus.name_len_out, 5);
    send_idle();
    drain("M_drain");

    // Push the 4-bit counter past saturation
    send_name(30);
    send_name(2);
    send_idle();
    drain("S_drain");
    chk_disc("S");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
